// File: rtl/cpu_pkg.sv
// Shared CPU control constants: RegDst select codes, architectural register
// numbers and default field widths.
package cpu_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int SEL_W_DEF  = 3;

    localparam int RDST_RT = 0;
    localparam int RDST_RD = 1;
    localparam int RDST_RA = 2;
    localparam int RDST_SP = 3;
    localparam int RDST_FP = 4;

    localparam int REG_ZERO = 0;
    localparam int REG_SP   = 29;
    localparam int REG_FP   = 30;
    localparam int REG_RA   = 31;

    function automatic logic is_legal_code(input int code);
        return (code >= RDST_RT) && (code <= RDST_FP);
    endfunction

endpackage

// File: rtl/dst_fifo.sv
// Generic DEPTH x ADDR_W FIFO with occupancy count; exposes every slot and
// its valid bit so the parent can compare against all pending entries.
module dst_fifo #(
    parameter  int DEPTH  = 4,
    parameter  int ADDR_W = 5,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic [ADDR_W-1:0]              push_addr,
    input  logic                           pop,
    output logic                           full,
    output logic                           empty,
    output logic [CNT_W-1:0]               count,
    output logic [ADDR_W-1:0]              head_addr,
    output logic [DEPTH-1:0][ADDR_W-1:0]   entries,
    output logic [DEPTH-1:0]               entry_valid
);

    logic [DEPTH-1:0][ADDR_W-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic                         push_en, pop_en;
    logic [PTR_W-1:0]             offset;

    // Full/empty come from the count so pointer equality is never ambiguous.
    always_comb begin
        full    = (count_q == CNT_W'(DEPTH));
        empty   = (count_q == '0);
        push_en = push && !full;
        pop_en  = pop && !empty;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) begin
            mem_d[wr_ptr_q] = push_addr;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // A slot is live when its distance from the head is below the count.
    always_comb begin
        offset      = '0;
        entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset         = PTR_W'(i) - rd_ptr_q;
            entry_valid[i] = ({1'b0, offset} < count_q);
        end
    end

    always_comb begin
        count     = count_q;
        entries   = mem_q;
        head_addr = empty ? '0 : mem_q[rd_ptr_q];
    end

endmodule

// File: rtl/reg_dst_tracker.sv
// Write-destination select plus pending-destination queue between decode and
// writeback, with RAW hazard lookup for two source registers.
module reg_dst_tracker
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int SEL_W   = SEL_W_DEF,
    parameter int DEPTH   = 4,
    parameter int RA_ADDR = REG_RA,
    parameter int SP_ADDR = REG_SP,
    parameter int FP_ADDR = REG_FP
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SEL_W-1:0]        reg_dst,
    input  logic [ADDR_W-1:0]       in_rt,
    input  logic [ADDR_W-1:0]       in_rd,
    input  logic                    dst_valid,
    output logic                    dst_ready,
    input  logic                    wb_pop,
    output logic [ADDR_W-1:0]       wb_addr,
    output logic                    wb_valid,
    input  logic [ADDR_W-1:0]       query_a,
    input  logic [ADDR_W-1:0]       query_b,
    output logic                    hazard_a,
    output logic                    hazard_b,
    output logic                    sel_err,
    output logic [ADDR_W-1:0]       last_dst,
    output logic [$clog2(DEPTH):0]  count
);

    logic [ADDR_W-1:0]             sel_addr;
    logic                          sel_legal;
    logic                          push;
    logic                          fifo_full, fifo_empty;
    logic [DEPTH-1:0][ADDR_W-1:0]  fifo_entries;
    logic [DEPTH-1:0]              fifo_entry_valid;
    logic [ADDR_W-1:0]             last_dst_q, last_dst_d;
    logic                          sel_err_q, sel_err_d;

    // Illegal codes fall back to the last accepted destination.
    always_comb begin
        sel_legal = is_legal_code(int'(reg_dst));
        sel_addr  = last_dst_q;
        case (int'(reg_dst))
            RDST_RT: sel_addr = in_rt;
            RDST_RD: sel_addr = in_rd;
            RDST_RA: sel_addr = ADDR_W'(RA_ADDR);
            RDST_SP: sel_addr = ADDR_W'(SP_ADDR);
            RDST_FP: sel_addr = ADDR_W'(FP_ADDR);
            default: sel_addr = last_dst_q;
        endcase
    end

    always_comb begin
        dst_ready  = !fifo_full;
        push       = dst_valid && !fifo_full;
        sel_err_d  = push && !sel_legal;
        last_dst_d = push ? sel_addr : last_dst_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_dst_q <= '0;
            sel_err_q  <= 1'b0;
        end else begin
            last_dst_q <= last_dst_d;
            sel_err_q  <= sel_err_d;
        end
    end

    dst_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_dst_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_addr   (sel_addr),
        .pop         (wb_pop),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .count       (count),
        .head_addr   (wb_addr),
        .entries     (fifo_entries),
        .entry_valid (fifo_entry_valid)
    );

    // Register $zero is never a real dependency, so it never flags a hazard.
    always_comb begin
        hazard_a = 1'b0;
        hazard_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_entry_valid[i] && (fifo_entries[i] == query_a) &&
                (query_a != ADDR_W'(REG_ZERO))) begin
                hazard_a = 1'b1;
            end
            if (fifo_entry_valid[i] && (fifo_entries[i] == query_b) &&
                (query_b != ADDR_W'(REG_ZERO))) begin
                hazard_b = 1'b1;
            end
        end
    end

    always_comb begin
        wb_valid = !fifo_empty;
        sel_err  = sel_err_q;
        last_dst = last_dst_q;
    end

endmodule

// File: tb/tb_reg_dst_tracker.sv
// Bench for reg_dst_tracker: directed vector table, hand sequences for wrap
// and mid-stream reset, then random traffic against a queue-based model.
module tb_reg_dst_tracker;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] reg_dst;
    logic [4:0] in_rt, in_rd;
    logic       dst_valid, dst_ready;
    logic       wb_pop, wb_valid;
    logic [4:0] wb_addr;
    logic [4:0] query_a, query_b;
    logic       hazard_a, hazard_b, sel_err;
    logic [4:0] last_dst;
    logic [2:0] count;

    int tests = 0;
    int fails = 0;

    logic [4:0] mq[$];
    logic [4:0] m_last;
    logic       m_err;

    always #5 clk = ~clk;

    reg_dst_tracker #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .reg_dst   (reg_dst),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .dst_valid (dst_valid),
        .dst_ready (dst_ready),
        .wb_pop    (wb_pop),
        .wb_addr   (wb_addr),
        .wb_valid  (wb_valid),
        .query_a   (query_a),
        .query_b   (query_b),
        .hazard_a  (hazard_a),
        .hazard_b  (hazard_b),
        .sel_err   (sel_err),
        .last_dst  (last_dst),
        .count     (count)
    );

    typedef struct {
        logic [2:0] code;
        logic [4:0] rt, rd;
        logic       dv, pop;
        logic [4:0] qa, qb;
        int         e_cnt;
        logic       e_valid;
        logic [4:0] e_addr;
        logic       e_ready, e_err;
        logic [4:0] e_last;
        logic       e_ha, e_hb;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic model_hz(input logic [4:0] q);
        if (q == 0) return 1'b0;
        foreach (mq[i]) if (mq[i] == q) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_edge(input logic [2:0] code, input logic [4:0] rt, rd,
                              input logic dv, pop);
        logic       do_push, do_pop;
        logic [4:0] sel;
        do_push = dv && (mq.size() < DEPTH);
        do_pop  = pop && (mq.size() > 0);
        case (code)
            3'd0:    sel = rt;
            3'd1:    sel = rd;
            3'd2:    sel = 5'd31;
            3'd3:    sel = 5'd29;
            3'd4:    sel = 5'd30;
            default: sel = m_last;
        endcase
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            mq.push_back(sel);
            m_last = sel;
        end
        m_err = do_push && (code > 3'd4);
    endtask

    task automatic run_cycle(input logic [2:0] code, input logic [4:0] rt, rd,
                             input logic dv, pop, input logic [4:0] qa, qb);
        reg_dst   = code;
        in_rt     = rt;
        in_rd     = rd;
        dst_valid = dv;
        wb_pop    = pop;
        query_a   = qa;
        query_b   = qb;
        @(posedge clk);
        model_edge(code, rt, rd, dv, pop);
        #1;
    endtask

    task automatic check_model();
        chk("count",    int'(count),    mq.size());
        chk("wb_valid", int'(wb_valid), int'(mq.size() != 0));
        chk("wb_addr",  int'(wb_addr),  (mq.size() != 0) ? int'(mq[0]) : 0);
        chk("ready",    int'(dst_ready), int'(mq.size() != DEPTH));
        chk("sel_err",  int'(sel_err),  int'(m_err));
        chk("last_dst", int'(last_dst), int'(m_last));
        chk("hazard_a", int'(hazard_a), int'(model_hz(query_a)));
        chk("hazard_b", int'(hazard_b), int'(model_hz(query_b)));
    endtask

    initial begin
        //            code  rt  rd dv pop qa  qb  cnt v addr rdy err last ha hb
        tbl[0]  = '{3'd0, 8,  9, 1, 0,  0,  0,  1, 1,  8, 1, 0,  8, 0, 0};
        tbl[1]  = '{3'd1, 8,  9, 1, 0,  0,  0,  2, 1,  8, 1, 0,  9, 0, 0};
        tbl[2]  = '{3'd2, 8,  9, 1, 0,  0,  0,  3, 1,  8, 1, 0, 31, 0, 0};
        tbl[3]  = '{3'd3, 8,  9, 1, 0,  0,  0,  4, 1,  8, 0, 0, 29, 0, 0};
        tbl[4]  = '{3'd4, 8,  9, 1, 0,  0,  0,  4, 1,  8, 0, 0, 29, 0, 0};
        tbl[5]  = '{3'd0, 8,  9, 0, 1,  0,  0,  3, 1,  9, 1, 0, 29, 0, 0};
        tbl[6]  = '{3'd0, 8,  9, 0, 1,  0,  0,  2, 1, 31, 1, 0, 29, 0, 0};
        tbl[7]  = '{3'd0, 8,  9, 0, 1,  0,  0,  1, 1, 29, 1, 0, 29, 0, 0};
        tbl[8]  = '{3'd0, 8,  9, 0, 1,  0,  0,  0, 0,  0, 1, 0, 29, 0, 0};
        tbl[9]  = '{3'd1, 8, 12, 1, 0,  0,  0,  1, 1, 12, 1, 0, 12, 0, 0};
        tbl[10] = '{3'd6, 8, 20, 1, 0,  0,  0,  2, 1, 12, 1, 1, 12, 0, 0};
        tbl[11] = '{3'd0, 8,  9, 0, 0,  0,  0,  2, 1, 12, 1, 0, 12, 0, 0};
        tbl[12] = '{3'd0, 0,  9, 1, 1,  0,  0,  2, 1, 12, 1, 0,  0, 0, 0};
        tbl[13] = '{3'd0, 0,  9, 0, 0, 12,  0,  2, 1, 12, 1, 0,  0, 1, 0};
        tbl[14] = '{3'd0, 0,  9, 0, 1, 12,  0,  1, 1,  0, 1, 0,  0, 0, 0};
        tbl[15] = '{3'd0, 5,  9, 1, 0,  5,  0,  2, 1,  0, 1, 0,  5, 1, 0};
        tbl[16] = '{3'd2, 5,  9, 1, 1,  0, 31,  2, 1,  5, 1, 0, 31, 0, 1};
        tbl[17] = '{3'd0, 5,  9, 0, 1, 31,  0,  1, 1, 31, 1, 0, 31, 1, 0};

        reset = 1'b1;
        reg_dst = '0; in_rt = '0; in_rd = '0; dst_valid = 1'b0; wb_pop = 1'b0;
        query_a = '0; query_b = '0;
        m_last = '0; m_err = 1'b0;
        #2;
        chk("rst_count",    int'(count),    0);
        chk("rst_wb_valid", int'(wb_valid), 0);
        chk("rst_wb_addr",  int'(wb_addr),  0);
        chk("rst_last_dst", int'(last_dst), 0);
        chk("rst_sel_err",  int'(sel_err),  0);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            run_cycle(tbl[i].code, tbl[i].rt, tbl[i].rd, tbl[i].dv, tbl[i].pop,
                      tbl[i].qa, tbl[i].qb);
            chk($sformatf("v%0d_count", i),    int'(count),     tbl[i].e_cnt);
            chk($sformatf("v%0d_wb_valid", i), int'(wb_valid),  int'(tbl[i].e_valid));
            chk($sformatf("v%0d_wb_addr", i),  int'(wb_addr),   int'(tbl[i].e_addr));
            chk($sformatf("v%0d_ready", i),    int'(dst_ready), int'(tbl[i].e_ready));
            chk($sformatf("v%0d_sel_err", i),  int'(sel_err),   int'(tbl[i].e_err));
            chk($sformatf("v%0d_last_dst", i), int'(last_dst),  int'(tbl[i].e_last));
            chk($sformatf("v%0d_hazard_a", i), int'(hazard_a),  int'(tbl[i].e_ha));
            chk($sformatf("v%0d_hazard_b", i), int'(hazard_b),  int'(tbl[i].e_hb));
        end

        // push every cycle with alternating pops so the pointers wrap
        for (int i = 0; i < DEPTH + 3; i++) begin
            run_cycle(3'd0, 5'(i + 1), 5'd0, 1'b1, 1'(i % 2), 5'(i), 5'(i + 1));
            check_model();
        end
        while (mq.size() != 0) begin
            run_cycle(3'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd3, 5'd6);
            check_model();
        end

        // mid-stream reset with three pending entries
        for (int i = 0; i < 3; i++) begin
            run_cycle(3'd0, 5'(17 + i), 5'd0, 1'b1, 1'b0, 5'd17, 5'd18);
        end
        dst_valid = 1'b0;
        chk("pre_rst_count", int'(count), 3);
        #2 reset = 1'b1;
        #1;
        mq.delete();
        m_last = '0;
        m_err  = 1'b0;
        chk("midrst_count",    int'(count),    0);
        chk("midrst_wb_valid", int'(wb_valid), 0);
        chk("midrst_last_dst", int'(last_dst), 0);
        chk("midrst_hazard_a", int'(hazard_a), 0);
        chk("midrst_hazard_b", int'(hazard_b), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        run_cycle(3'd1, 5'd0, 5'd14, 1'b1, 1'b0, 5'd14, 5'd0);
        chk("post_rst_wb_valid", int'(wb_valid), 1);
        chk("post_rst_wb_addr",  int'(wb_addr),  14);
        check_model();

        for (int i = 0; i < 400; i++) begin
            run_cycle(3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), 1'($urandom_range(0, 9) < 7),
                      1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)));
            check_model();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_dst_tracker.md
Name: reg_dst_tracker

Overview:
Parametrised successor to the write-register destination mux. It selects the destination register from a RegDst code and queues it in a DEPTH-entry FIFO between decode and writeback. Each queued destination is presented to the register bank in order. Two source-register queries are checked for RAW hazards against all pending destinations, so the control unit can stall.

Parameters:
ADDR_W, 5, register address width
SEL_W, 3, RegDst code width
DEPTH, 4, pending-destination FIFO depth; power of two, >= 2
RA_ADDR, 31, destination for code 2 (jal link register)
SP_ADDR, 29, destination for code 3 (stack pointer)
FP_ADDR, 30, destination for code 4 (frame pointer)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
reg_dst  input  SEL_W  destination select code from control unit
in_rt  input  ADDR_W  instruction rt field
in_rd  input  ADDR_W  instruction rd field
dst_valid  input  1  decode offers a destination this cycle
dst_ready  output  1  FIFO can accept (= not full)
wb_pop  input  1  writeback consumed head entry
wb_addr  output  ADDR_W  head-entry destination (0 when empty)
wb_valid  output  1  FIFO not empty
query_a  input  ADDR_W  source register A (rs)
query_b  input  ADDR_W  source register B (rt)
hazard_a  output  1  query_a matches a pending entry
hazard_b  output  1  query_b matches a pending entry
sel_err  output  1  one-cycle pulse: illegal code accepted
last_dst  output  ADDR_W  most recently accepted destination
count  output  clog2(DEPTH)+1  number of pending entries

Behaviour:
- Reset (async, immediate): FIFO empty, count=0, wb_valid=0, wb_addr=0, last_dst=0, sel_err=0, hazard_a/b=0.
- Selection (combinational): code 0 -> in_rt, 1 -> in_rd, 2 -> RA_ADDR, 3 -> SP_ADDR, 4 -> FP_ADDR.
- Codes 5..2^SEL_W-1 are illegal and select last_dst (hold-last behaviour).
- Push when dst_valid && dst_ready.
  - The selected address is written at the tail and last_dst updates on the same edge.
  - An illegal code still pushes (last_dst value) and sel_err=1 for exactly the next cycle.
- dst_ready = (count != DEPTH). It does not depend on wb_pop, so there is no combinational pop->ready path.
  - dst_valid while full is ignored, with no state change and no sel_err.
- Pop when wb_pop && wb_valid; the head advances. wb_pop while empty is ignored.
- Simultaneous push and pop (not full, not empty): both occur and count is unchanged.
  - On an empty FIFO, wb_pop has no effect, the push occurs and count becomes 1.
- Latency: a pushed entry appears on wb_addr/wb_valid the cycle after the push edge if the FIFO was empty.
- wb_addr shows the registered head entry, and 0 when empty.
- Pointers wrap modulo DEPTH. Full/empty are derived from count, not from pointer equality.
- Hazards are combinational. hazard_x=1 iff query_x != 0 and query_x equals the address of any valid entry.
  - Only registered entries are compared; the same-cycle push is not.
  - Entries holding address 0 never cause a hazard.
  - An entry popped on this edge stops causing a hazard the next cycle.
- Reset asserted mid-operation discards all pending entries; no partial state remains.

Decomposition:
- Shared package (cpu_pkg):
  - RegDst code localparams (RDST_RT=0, RDST_RD=1, RDST_RA=2, RDST_SP=3, RDST_FP=4).
  - Register-number constants ($zero, $sp, $fp, $ra).
  - ADDR_W default.
- One natural sub-module: dst_fifo, a generic DEPTH x ADDR_W FIFO with count, exposing all entries and their valid bits for the hazard compare.
- The selection mux, sel_err and last_dst registers, and hazard compare stay in reg_dst_tracker.

Test Plan:
- Reset then codes 0,1,2,3,4 with in_rt=8, in_rd=9, one per cycle, no pops
  -> wb_addr=8, count=4, dst_ready=0, code-4 push blocked.
  - Pop four times -> wb_addr sequence 8,9,31,29, then wb_valid=0, wb_addr=0.
- Push code 1 (in_rd=12), then code 6
  -> both push 12, last_dst=12, sel_err high exactly one cycle after the code-6 edge, count=2.
- Pending {12, 0}, query_a=12, query_b=0
  -> hazard_a=1, hazard_b=0.
  - Pop entry 12 -> hazard_a=0 the following cycle.
- FIFO holding 2 entries, push code 2 and pop in the same cycle
  -> count stays 2, the new tail is 31, the head advances.
  - Fill to full with DEPTH+3 push/pop cycles -> order preserved across wrap.
- Assert reset mid-stream with count=3
  -> immediately count=0, wb_valid=0, last_dst=0, hazards=0.
  - The first push after release -> wb_addr valid one cycle later.
